// File: rtl/reg_bank_ab.sv
// -----------------------------------------------------------------------------
// reg_bank_ab
//
// Architectural register file for the multicycle MIPS datapath, sitting just
// after the register-destination select mux. Holds NUM_REGS general purpose
// registers, exposes two combinational read ports and the A/B operand latches
// that feed the ALU stage. A write and an A/B capture in the same cycle are
// forwarded so the latch picks up the value being written.
//
// Ports:
//   clk         in   system clock, all state updates on the rising edge
//   reset       in   synchronous active-high reset
//   reg_write   in   write enable for the register array
//   write_reg   in   [ADDR_W]  destination register address
//   write_data  in   [DATA_W]  value to write
//   read_reg1   in   [ADDR_W]  read address port 1 (rs)
//   read_reg2   in   [ADDR_W]  read address port 2 (rt)
//   load_ab     in   capture the (forwarded) read values into A/B
//   read_data1  out  [DATA_W]  combinational contents of read_reg1
//   read_data2  out  [DATA_W]  combinational contents of read_reg2
//   a_out       out  [DATA_W]  A latch (registered rs operand)
//   b_out       out  [DATA_W]  B latch (registered rt operand)
// -----------------------------------------------------------------------------
module reg_bank_ab #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 5,
  parameter int                 NUM_REGS = 32,
  parameter logic [DATA_W-1:0]  SP_RESET = 227
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic              load_ab,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out
);

  // $sp lives in register 29 and comes out of reset pointing at SP_RESET.
  localparam int SP_IDX = 29;

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              write_en;
  logic [DATA_W-1:0] rd1_raw;
  logic [DATA_W-1:0] rd2_raw;
  logic [DATA_W-1:0] fwd1;
  logic [DATA_W-1:0] fwd2;

  // Writes to register 0 are dropped here, and every read path below also
  // masks address 0, so $zero reads as zero regardless of array contents.
  assign write_en = reg_write && (write_reg != '0);

  // ---------------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------------
  // NOTE: every entry is reset explicitly because software relies on $sp and
  // the zeroed registers right after reset; this keeps the array in flops
  // rather than letting it map to a RAM macro, which has no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        // NOTE: non-blocking assignments for all sequential state so every
        // flop samples pre-edge values, independent of statement order.
        regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
    end else if (write_en) begin
      regs[write_reg] <= write_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports and forwarding
  // ---------------------------------------------------------------------------
  // Raw ports show the array only: during a write cycle they still present
  // the old value. The forwarded copies feed the A/B latches so a same-cycle
  // write-then-capture sees the new value.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    rd1_raw = '0;
    rd2_raw = '0;
    fwd1    = '0;
    fwd2    = '0;

    if (read_reg1 != '0) rd1_raw = regs[read_reg1];
    if (read_reg2 != '0) rd2_raw = regs[read_reg2];

    fwd1 = rd1_raw;
    fwd2 = rd2_raw;
    // write_en already excludes register 0, so a write to $zero is never
    // forwarded into A or B.
    if (write_en && (write_reg == read_reg1)) fwd1 = write_data;
    if (write_en && (write_reg == read_reg2)) fwd2 = write_data;
  end

  assign read_data1 = rd1_raw;
  assign read_data2 = rd2_raw;

  // ---------------------------------------------------------------------------
  // A/B operand latches
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      a_out <= '0;
      b_out <= '0;
    end else if (load_ab) begin
      a_out <= fwd1;
      b_out <= fwd2;
    end
  end

endmodule

// File: tb/tb_reg_bank_ab.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_ab
//
// Self-checking bench for reg_bank_ab. Directed steps cover reset, basic
// write/read, register 0, forwarding into A/B, reset priority and hold, then
// a randomized phase is checked against a simple array model of the register
// file kept in the bench.
// -----------------------------------------------------------------------------
module tb_reg_bank_ab;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;
  localparam logic [DATA_W-1:0] SP_VAL = 32'd227;

  logic              clk = 1'b0;
  logic              reset;
  logic              reg_write;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic              load_ab;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;

  reg_bank_ab #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NREGS),
    .SP_RESET(SP_VAL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .reg_write (reg_write),
    .write_reg (write_reg),
    .write_data(write_data),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .load_ab   (load_ab),
    .read_data1(read_data1),
    .read_data2(read_data2),
    .a_out     (a_out),
    .b_out     (b_out)
  );

  always #5 clk = ~clk;

  // Reference model: the architectural register contents and the A/B latches.
  logic [DATA_W-1:0] mdl_regs [NREGS];
  logic [DATA_W-1:0] mdl_a;
  logic [DATA_W-1:0] mdl_b;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural read: register 0 is always zero.
  function automatic logic [DATA_W-1:0] arch_read(input int r);
    return (r == 0) ? '0 : mdl_regs[r];
  endfunction

  // What an operand capture sees: a write in flight to the same nonzero
  // register wins over the stored value.
  function automatic logic [DATA_W-1:0] operand(input int r, input logic we,
                                                input int wr,
                                                input logic [DATA_W-1:0] wd);
    if (r != 0 && we && wr == r) return wd;
    return arch_read(r);
  endfunction

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    if (reset) begin
      foreach (mdl_regs[i]) mdl_regs[i] = '0;
      mdl_regs[29] = SP_VAL;
      mdl_a = '0;
      mdl_b = '0;
    end else begin
      if (load_ab) begin
        mdl_a = operand(int'(read_reg1), reg_write, int'(write_reg), write_data);
        mdl_b = operand(int'(read_reg2), reg_write, int'(write_reg), write_data);
      end
      if (reg_write && write_reg != 0) mdl_regs[write_reg] = write_data;
    end
  endtask

  // One clock cycle: drive inputs, check the raw read ports against the
  // pre-edge model at the falling edge, advance across the rising edge, then
  // check the latches just after it.
  task automatic cycle(input logic rst, input logic we, input int wr,
                       input logic [DATA_W-1:0] wd, input int r1, input int r2,
                       input logic ld, input string tag);
    reset      = rst;
    reg_write  = we;
    write_reg  = ADDR_W'(wr);
    write_data = wd;
    read_reg1  = ADDR_W'(r1);
    read_reg2  = ADDR_W'(r2);
    load_ab    = ld;
    @(negedge clk);
    if (!$isunknown(mdl_regs[29])) begin
      check({tag, ".rd1"}, read_data1, arch_read(r1));
      check({tag, ".rd2"}, read_data2, arch_read(r2));
    end
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".a"}, a_out, mdl_a);
    check({tag, ".b"}, b_out, mdl_b);
  endtask

  initial begin
    // Model state is unknown until the first reset edge, just like the DUT.
    foreach (mdl_regs[i]) mdl_regs[i] = 'x;
    mdl_a = 'x;
    mdl_b = 'x;

    // ---- Reset ----
    cycle(1'b1, 1'b0, 0, '0, 0, 0, 1'b0, "reset");
    cycle(1'b0, 1'b0, 0, '0, 29, 5, 1'b0, "post_reset");
    check("reset.sp", read_data1, 32'd227);
    check("reset.r5", read_data2, 32'd0);
    check("reset.a0", a_out, 32'd0);
    check("reset.b0", b_out, 32'd0);

    // ---- Basic write/read (old value during the write cycle) ----
    cycle(1'b0, 1'b1, 8, 32'hDEADBEEF, 8, 0, 1'b0, "wr8");
    reg_write = 1'b0;
    #1;
    check("wr8.after", read_data1, 32'hDEADBEEF);

    // ---- Register 0 protection ----
    cycle(1'b0, 1'b1, 0, 32'hFFFFFFFF, 0, 0, 1'b1, "wr0_ld");
    check("r0.a", a_out, 32'd0);
    cycle(1'b0, 1'b0, 0, '0, 0, 8, 1'b1, "r0_read");
    check("r0.rd1", read_data1, 32'd0);

    // ---- Forwarding into the latch ----
    cycle(1'b0, 1'b1, 31, 32'h00400010, 31, 29, 1'b1, "fwd");
    check("fwd.a", a_out, 32'h00400010);
    check("fwd.b", b_out, 32'd227);
    // Same register on both ports with forwarding.
    cycle(1'b0, 1'b1, 12, 32'h1234_5678, 12, 12, 1'b1, "fwd_same");
    check("fwd_same.ab", a_out, b_out);

    // ---- Reset priority ----
    cycle(1'b0, 1'b1, 29, 32'd99, 0, 0, 1'b0, "sp_clobber");
    cycle(1'b1, 1'b1, 29, 32'd5, 29, 31, 1'b1, "rst_prio");
    cycle(1'b0, 1'b0, 0, '0, 29, 31, 1'b0, "rst_prio_rd");
    check("rst_prio.sp", read_data1, 32'd227);
    check("rst_prio.ra", read_data2, 32'd0);
    check("rst_prio.a", a_out, 32'd0);
    check("rst_prio.b", b_out, 32'd0);

    // ---- Hold ----
    cycle(1'b0, 1'b1, 8, 32'd3, 0, 0, 1'b0, "hold_w8");
    cycle(1'b0, 1'b1, 9, 32'd4, 0, 0, 1'b0, "hold_w9");
    cycle(1'b0, 1'b0, 0, '0, 8, 9, 1'b1, "hold_ld");
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 8, 32'hAAAA_0000 + i, 10 + i, 20 + i, 1'b0, "hold");
      check("hold.a", a_out, 32'd3);
      check("hold.b", b_out, 32'd4);
    end

    // ---- Randomized traffic, biased toward address collisions ----
    for (int n = 0; n < 600; n++) begin
      int r1, r2, wr;
      logic rst, we, ld;
      logic [DATA_W-1:0] wd;
      r1  = $urandom_range(0, NREGS - 1);
      r2  = ($urandom_range(0, 7) == 0) ? r1 : $urandom_range(0, NREGS - 1);
      case ($urandom_range(0, 3))
        0:       wr = r1;
        1:       wr = r2;
        2:       wr = ($urandom_range(0, 1) == 1) ? 29 : 31;
        default: wr = $urandom_range(0, NREGS - 1);
      endcase
      wd  = $urandom();
      we  = ($urandom_range(0, 3) != 0);
      ld  = ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 59) == 0);
      cycle(rst, we, wr, wd, r1, r2, ld, "rand");
    end

    // ---- Final sweep of every register through both read ports ----
    for (int r = 0; r < NREGS; r++) begin
      cycle(1'b0, 1'b0, 0, '0, r, NREGS - 1 - r, 1'b1, "sweep");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_ab.md
Name: reg_bank_ab

Overview:
- Register file for the multicycle MIPS datapath, directly downstream of the register-destination select mux.
- Consumes the 5-bit destination address produced by that mux (rt, 29, 31, rd or rs) plus write data from the writeback mux.
- Provides two asynchronous read ports and the datapath A/B operand latches, with same-cycle write-to-latch forwarding.

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of architectural registers (2**ADDR_W).
- SP_RESET, 227, reset value of register 29 ($sp).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- reg_write  input  1  write enable for the register array.
- write_reg  input  ADDR_W  destination register address from the register-destination mux.
- write_data  input  DATA_W  value to write.
- read_reg1  input  ADDR_W  read address port 1 (rs).
- read_reg2  input  ADDR_W  read address port 2 (rt).
- load_ab  input  1  capture read ports into the A/B latches.
- read_data1  output  DATA_W  combinational contents of read_reg1.
- read_data2  output  DATA_W  combinational contents of read_reg2.
- a_out  output  DATA_W  A latch (registered rs operand).
- b_out  output  DATA_W  B latch (registered rt operand).

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous, active-high, and sampled on the rising edge of clk.
  - At a reset edge: every register goes to 0 except reg[29] = SP_RESET. a_out = 0 and b_out = 0.
  - Reset has priority over reg_write and load_ab in the same cycle; neither takes effect.
  - Reset asserted mid-sequence discards any in-flight write or latch.
- Register 0:
  - Hardwired zero. Writes to address 0 are ignored.
  - Reads of address 0 always return 0 on read_data1/2, a_out and b_out, including via forwarding.
- Write:
  - On a rising edge with reg_write=1 and write_reg!=0: reg[write_reg] <= write_data.
  - The new value is visible on read_data1/2 after the edge (latency 1).
- Read ports:
  - read_dataN = reg[read_regN], purely combinational from the array.
  - No bypass on the raw read ports: during the write cycle they still show the old value.
- A/B latches:
  - On a rising edge with load_ab=1: a_out <= fwd(read_reg1) and b_out <= fwd(read_reg2).
  - fwd(r) = write_data if reg_write=1, write_reg==r and r!=0; otherwise reg[r].
  - The latch therefore captures the post-write value when a write and a load target the same register in one cycle.
  - With load_ab=0, a_out and b_out hold their values.
- Simultaneous events:
  - Write and load to different registers: each proceeds independently.
  - read_reg1==read_reg2: a_out and b_out receive identical values.
  - write_reg 29 or 31 (from the fixed mux inputs) is written like any other register; there is no protection on $sp or $ra.
- Width rules:
  - All addresses are ADDR_W bits; there is no out-of-range case.
  - Data is stored unmodified: no sign extension, no truncation.
- Structure:
  - Array of NUM_REGS x DATA_W flops; no RAM inference is required.
  - Explicit register-0 masking on every output path.

Test Plan:
- Reset: assert reset for 1 cycle -> read_reg1=29 gives read_data1=227; read_reg2=5 gives read_data2=0; a_out=b_out=0.
- Basic write/read: reg_write=1, write_reg=8, write_data=0xDEADBEEF, one edge -> read_reg1=8 gives read_data1=0xDEADBEEF next cycle; during the write cycle read_data1 shows the old value 0.
- Register 0 protection: write_reg=0, write_data=0xFFFFFFFF, reg_write=1, then load_ab with read_reg1=0 -> read_data1=0 and a_out=0.
- Forwarding into the latch: reg_write=1, write_reg=31, write_data=0x00400010 and load_ab=1, read_reg1=31, read_reg2=29, all in the same cycle -> a_out=0x00400010 and b_out=227.
- Reset priority: reset=1, reg_write=1, write_reg=29, write_data=5, load_ab=1 in the same cycle -> reg[29]=227 and a_out=b_out=0 afterwards.
- Hold: load A/B with regs 8 and 9 (values 3 and 4), then change read_reg1/2 with load_ab=0 for 3 cycles -> a_out=3 and b_out=4 are held.
